// File: rtl/memory_stage_pkg.sv
// Shared RISC-V pipeline encodings used by the memory stage: load/store width codes,
// writeback result selects, the memory FSM states and the M pipeline register layout.
package riscv_pkg;

    localparam logic [2:0] WS_W  = 3'b000;
    localparam logic [2:0] WS_HS = 3'b001;
    localparam logic [2:0] WS_BS = 3'b010;
    localparam logic [2:0] WS_HU = 3'b101;
    localparam logic [2:0] WS_BU = 3'b110;

    localparam logic [2:0] RS_ALU = 3'b000;
    localparam logic [2:0] RS_MEM = 3'b001;
    localparam logic [2:0] RS_PC4 = 3'b010;
    localparam logic [2:0] RS_IMM = 3'b011;
    localparam logic [2:0] RS_TGT = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } mem_state_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_target;
        logic [31:0] pc_plus4;
        logic [31:0] imm_ext;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [2:0]  width_src;
        logic [2:0]  result_src;
        logic        mem_write;
        logic        reg_write;
    } m_reg_t;

    function automatic logic is_half(input logic [2:0] ws);
        return (ws == WS_HS) || (ws == WS_HU);
    endfunction

    function automatic logic is_byte(input logic [2:0] ws);
        return (ws == WS_BS) || (ws == WS_BU);
    endfunction

    function automatic logic is_mem_op(input logic [2:0] rs, input logic mw);
        return (rs == RS_MEM) || mw;
    endfunction

    // Codes that are neither half nor byte are treated as full-word accesses.
    function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] ws);
        if (is_byte(ws))
            return 1'b0;
        else if (is_half(ws))
            return off[0];
        else
            return off != 2'b00;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] off, input logic [2:0] ws);
        if (is_half(ws))
            return 4'b0011 << {off[1], 1'b0};
        else if (is_byte(ws))
            return 4'b0001 << off;
        else
            return 4'b1111;
    endfunction

    function automatic logic [31:0] store_data(input logic [31:0] wd, input logic [2:0] ws);
        if (is_half(ws))
            return {2{wd[15:0]}};
        else if (is_byte(ws))
            return {4{wd[7:0]}};
        else
            return wd;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Request/response data-memory bus between the memory stage (master) and data memory (slave).
interface memory_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/memory_stage_flop.sv
// Parameterised pipeline flop with async reset, synchronous clear and enable (clear wins over enable).
module flopenrc_ar #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/memory_stage_load_extend.sv
// Aligns the addressed bytes of a read word down to bit 0 and sign/zero-extends them by load width.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  width_src,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = shifted;
        case (width_src)
            WS_HS:   data = {{16{shifted[15]}}, shifted[15:0]};
            WS_BS:   data = {{24{shifted[7]}},  shifted[7:0]};
            WS_HU:   data = {16'h0000, shifted[15:0]};
            WS_BU:   data = {24'h000000, shifted[7:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline M stage: holds the execute results, runs the data-memory handshake for loads/stores
// and presents writeback and forwarding values.
module memory_stage
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic [31:0] alu_result_e_i,
    input  logic [31:0] write_data_e_i,
    input  logic [31:0] pc_target_e_i,
    input  logic [31:0] pc_plus4_e_i,
    input  logic [31:0] imm_ext_e_i,
    input  logic [4:0]  rd_e_i,
    input  logic [2:0]  funct3_e_i,
    input  logic [2:0]  width_src_e_i,
    input  logic [2:0]  result_src_e_i,
    input  logic        mem_write_e_i,
    input  logic        reg_write_e_i,

    input  logic        stall_m_i,
    input  logic        flush_m_i,

    memory_stage_if.master dmem,

    output logic [31:0] alu_result_m_o,
    output logic [31:0] read_data_m_o,
    output logic [31:0] pc_target_m_o,
    output logic [31:0] pc_plus4_m_o,
    output logic [31:0] imm_ext_m_o,
    output logic [4:0]  rd_m_o,
    output logic [2:0]  result_src_m_o,
    output logic        reg_write_m_o,

    output logic [31:0] forward_data_m_o,
    output logic        mem_busy_o,
    output logic        misaligned_m_o
);

    m_reg_t      m_d;
    m_reg_t      m_q;
    mem_state_t  state;
    logic        req_q;
    logic [31:0] rdata_q;
    logic [31:0] load_data;
    logic [2:0]  unused_funct3;

    logic capture;
    logic inc_go;
    logic m_mem;
    logic m_mis;
    logic m_go;

    always_comb begin
        m_d.alu_result = alu_result_e_i;
        m_d.write_data = write_data_e_i;
        m_d.pc_target  = pc_target_e_i;
        m_d.pc_plus4   = pc_plus4_e_i;
        m_d.imm_ext    = imm_ext_e_i;
        m_d.rd         = rd_e_i;
        m_d.funct3     = funct3_e_i;
        m_d.width_src  = width_src_e_i;
        m_d.result_src = result_src_e_i;
        m_d.mem_write  = mem_write_e_i;
        m_d.reg_write  = reg_write_e_i;
    end

    flopenrc_ar #(.WIDTH($bits(m_reg_t))) u_m_reg (
        .clk (clk_i),
        .rst (reset_i),
        .en  (!stall_m_i),
        .clr (flush_m_i),
        .d   (m_d),
        .q   (m_q)
    );

    load_extend u_load_extend (
        .rdata     (dmem.rdata),
        .offset    (m_q.alu_result[1:0]),
        .width_src (m_q.width_src),
        .data      (load_data)
    );

    assign capture = !stall_m_i && !flush_m_i;
    assign inc_go  = is_mem_op(result_src_e_i, mem_write_e_i)
                     && !is_misaligned(alu_result_e_i[1:0], width_src_e_i);
    assign m_mem   = is_mem_op(m_q.result_src, m_q.mem_write);
    assign m_mis   = m_mem && is_misaligned(m_q.alu_result[1:0], m_q.width_src);
    assign m_go    = m_mem && !m_mis;

    // Requests are launched on the same edge that loads the op into M, so a granted
    // single-cycle memory gives a two-cycle load. A flush that coincides with the
    // response needs no drain because nothing is left in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= ST_IDLE;
            req_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_m_i) begin
                        state <= ST_IDLE;
                    end else if (capture) begin
                        if (inc_go) begin
                            state <= ST_REQ;
                            req_q <= 1'b1;
                        end
                    end else if (m_go) begin
                        state <= ST_REQ;
                        req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (flush_m_i) begin
                        req_q <= 1'b0;
                        state <= (dmem.gnt && !dmem.rvalid) ? ST_DRAIN : ST_IDLE;
                    end else if (dmem.gnt) begin
                        req_q <= 1'b0;
                        if (dmem.rvalid) begin
                            rdata_q <= load_data;
                            state   <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem.rvalid) begin
                        if (flush_m_i) begin
                            state <= ST_IDLE;
                        end else begin
                            rdata_q <= load_data;
                            state   <= ST_DONE;
                        end
                    end else if (flush_m_i) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    if (flush_m_i) begin
                        state <= ST_IDLE;
                    end else if (!stall_m_i) begin
                        if (inc_go) begin
                            state <= ST_REQ;
                            req_q <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (dmem.rvalid)
                        state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Bus fields are gated by the request so the port idles at zero and stays steady until granted.
    assign dmem.req   = req_q;
    assign dmem.we    = req_q & m_q.mem_write;
    assign dmem.addr  = req_q ? m_q.alu_result : '0;
    assign dmem.wdata = req_q ? store_data(m_q.write_data, m_q.width_src) : '0;
    assign dmem.be    = req_q ? byte_enable(m_q.alu_result[1:0], m_q.width_src) : 4'b0000;

    assign mem_busy_o = ((state == ST_IDLE) && m_go)
                        || (state == ST_REQ)
                        || (state == ST_WAIT)
                        || (state == ST_DRAIN);

    assign misaligned_m_o = m_mis;
    assign reg_write_m_o  = m_q.reg_write & ~m_mis;
    assign alu_result_m_o = m_q.alu_result;
    assign read_data_m_o  = rdata_q;
    assign pc_target_m_o  = m_q.pc_target;
    assign pc_plus4_m_o   = m_q.pc_plus4;
    assign imm_ext_m_o    = m_q.imm_ext;
    assign rd_m_o         = m_q.rd;
    assign result_src_m_o = m_q.result_src;
    assign unused_funct3  = m_q.funct3;

    always_comb begin
        forward_data_m_o = '0;
        case (m_q.result_src)
            RS_ALU:  forward_data_m_o = m_q.alu_result;
            RS_MEM:  forward_data_m_o = rdata_q;
            RS_PC4:  forward_data_m_o = m_q.pc_plus4;
            RS_IMM:  forward_data_m_o = m_q.imm_ext;
            RS_TGT:  forward_data_m_o = m_q.pc_target;
            default: forward_data_m_o = '0;
        endcase
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage; the hazard unit is modelled as stall = busy | hold.
module tb_memory_stage;

    localparam logic [2:0] T_WS_W  = 3'b000;
    localparam logic [2:0] T_WS_HS = 3'b001;
    localparam logic [2:0] T_WS_BS = 3'b010;
    localparam logic [2:0] T_WS_BU = 3'b110;
    localparam logic [2:0] T_RS_ALU = 3'b000;
    localparam logic [2:0] T_RS_MEM = 3'b001;
    localparam logic [2:0] T_RS_PC4 = 3'b010;
    localparam logic [2:0] T_RS_IMM = 3'b011;
    localparam logic [2:0] T_RS_TGT = 3'b100;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] alu_result_e_i, write_data_e_i, pc_target_e_i, pc_plus4_e_i, imm_ext_e_i;
    logic [4:0]  rd_e_i;
    logic [2:0]  funct3_e_i, width_src_e_i, result_src_e_i;
    logic        mem_write_e_i, reg_write_e_i;
    logic        stall_m_i, flush_m_i, hold;
    logic [31:0] alu_result_m_o, read_data_m_o, pc_target_m_o, pc_plus4_m_o, imm_ext_m_o;
    logic [4:0]  rd_m_o;
    logic [2:0]  result_src_m_o;
    logic        reg_write_m_o;
    logic [31:0] forward_data_m_o;
    logic        mem_busy_o, misaligned_m_o;

    int checks = 0;
    int passes = 0;

    memory_stage_if dmem ();

    memory_stage dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .alu_result_e_i   (alu_result_e_i),
        .write_data_e_i   (write_data_e_i),
        .pc_target_e_i    (pc_target_e_i),
        .pc_plus4_e_i     (pc_plus4_e_i),
        .imm_ext_e_i      (imm_ext_e_i),
        .rd_e_i           (rd_e_i),
        .funct3_e_i       (funct3_e_i),
        .width_src_e_i    (width_src_e_i),
        .result_src_e_i   (result_src_e_i),
        .mem_write_e_i    (mem_write_e_i),
        .reg_write_e_i    (reg_write_e_i),
        .stall_m_i        (stall_m_i),
        .flush_m_i        (flush_m_i),
        .dmem             (dmem),
        .alu_result_m_o   (alu_result_m_o),
        .read_data_m_o    (read_data_m_o),
        .pc_target_m_o    (pc_target_m_o),
        .pc_plus4_m_o     (pc_plus4_m_o),
        .imm_ext_m_o      (imm_ext_m_o),
        .rd_m_o           (rd_m_o),
        .result_src_m_o   (result_src_m_o),
        .reg_write_m_o    (reg_write_m_o),
        .forward_data_m_o (forward_data_m_o),
        .mem_busy_o       (mem_busy_o),
        .misaligned_m_o   (misaligned_m_o)
    );

    always #5 clk = ~clk;

    assign stall_m_i = mem_busy_o | hold;

    task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [2:0] ws, input logic [2:0] rs,
                                 input logic mw, input logic rw, input logic [4:0] rd);
        alu_result_e_i = alu;
        write_data_e_i = wd;
        width_src_e_i  = ws;
        funct3_e_i     = ws;
        result_src_e_i = rs;
        mem_write_e_i  = mw;
        reg_write_e_i  = rw;
        rd_e_i         = rd;
    endtask

    task automatic applyBubble();
        applyStimulus(32'h0, 32'h0, T_WS_W, T_RS_ALU, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic setBus(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        dmem.gnt    = gnt;
        dmem.rvalid = rvalid;
        dmem.rdata  = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    logic [2:0]  fwd_rs  [5] = '{T_RS_PC4, T_RS_IMM, T_RS_TGT, 3'b111, T_RS_ALU};
    logic [31:0] fwd_exp [5] = '{32'h0000_0204, 32'h0000_0ABC, 32'h0000_3000, 32'h0, 32'h0000_0055};

    initial begin
        reset_i = 1'b1;
        flush_m_i = 1'b0;
        hold = 1'b0;
        pc_target_e_i = 32'h0000_3000;
        pc_plus4_e_i  = 32'h0000_0204;
        imm_ext_e_i   = 32'h0000_0ABC;
        applyBubble();
        setBus(1'b0, 1'b0, 32'h0);

        @(negedge clk);
        checkOutput("rst_req",      32'(dmem.req), 32'd0);
        checkOutput("rst_busy",     32'(mem_busy_o), 32'd0);
        checkOutput("rst_be",       32'(dmem.be), 32'd0);
        checkOutput("rst_addr",     dmem.addr, 32'd0);
        checkOutput("rst_rdata",    read_data_m_o, 32'd0);
        checkOutput("rst_fwd",      forward_data_m_o, 32'd0);
        checkOutput("rst_pc4",      pc_plus4_m_o, 32'd0);
        checkOutput("rst_tgt",      pc_target_m_o, 32'd0);
        checkOutput("rst_imm",      imm_ext_m_o, 32'd0);
        checkOutput("rst_rs",       32'(result_src_m_o), 32'd0);
        checkOutput("rst_mis",      32'(misaligned_m_o), 32'd0);

        // LW 0x100, grant one cycle after request, data the cycle after
        reset_i = 1'b0;
        applyStimulus(32'h100, 32'h0, T_WS_W, T_RS_MEM, 1'b0, 1'b1, 5'd5);
        @(negedge clk);
        checkOutput("lw_req",   32'(dmem.req), 32'd1);
        checkOutput("lw_busy1", 32'(mem_busy_o), 32'd1);
        checkOutput("lw_addr",  dmem.addr, 32'h100);
        checkOutput("lw_we",    32'(dmem.we), 32'd0);
        checkOutput("lw_be",    32'(dmem.be), 32'hF);
        setBus(1'b1, 1'b0, 32'h0);
        applyBubble();
        @(negedge clk);
        checkOutput("lw_req_drop", 32'(dmem.req), 32'd0);
        checkOutput("lw_busy2",    32'(mem_busy_o), 32'd1);
        setBus(1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("lw_done_busy", 32'(mem_busy_o), 32'd0);
        checkOutput("lw_rdata",     read_data_m_o, 32'hDEAD_BEEF);
        checkOutput("lw_fwd",       forward_data_m_o, 32'hDEAD_BEEF);
        checkOutput("lw_regwrite",  32'(reg_write_m_o), 32'd1);
        checkOutput("lw_rd",        32'(rd_m_o), 32'd5);
        setBus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("lw_retire_busy", 32'(mem_busy_o), 32'd0);

        // LB 0x103 with grant and data in the same cycle, then LBU straight out of DONE
        applyStimulus(32'h103, 32'h0, T_WS_BS, T_RS_MEM, 1'b0, 1'b1, 5'd6);
        @(negedge clk);
        checkOutput("lb_req", 32'(dmem.req), 32'd1);
        checkOutput("lb_be",  32'(dmem.be), 32'h8);
        setBus(1'b1, 1'b1, 32'h80FF_FF00);
        applyBubble();
        @(negedge clk);
        checkOutput("lb_rdata", read_data_m_o, 32'hFFFF_FF80);
        checkOutput("lb_busy",  32'(mem_busy_o), 32'd0);
        setBus(1'b0, 1'b0, 32'h0);
        applyStimulus(32'h103, 32'h0, T_WS_BU, T_RS_MEM, 1'b0, 1'b1, 5'd6);
        @(negedge clk);
        checkOutput("lbu_req_b2b", 32'(dmem.req), 32'd1);
        setBus(1'b1, 1'b0, 32'h0);
        applyBubble();
        @(negedge clk);
        setBus(1'b0, 1'b1, 32'h80FF_FF00);
        @(negedge clk);
        checkOutput("lbu_rdata", read_data_m_o, 32'h0000_0080);
        setBus(1'b0, 1'b0, 32'h0);

        // SH 0x102, request held one cycle without grant
        applyStimulus(32'h102, 32'h1234_ABCD, T_WS_HS, T_RS_ALU, 1'b1, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("sh_req",   32'(dmem.req), 32'd1);
        checkOutput("sh_we",    32'(dmem.we), 32'd1);
        checkOutput("sh_be",    32'(dmem.be), 32'hC);
        checkOutput("sh_wdata", dmem.wdata, 32'hABCD_ABCD);
        applyBubble();
        @(negedge clk);
        checkOutput("sh_req_hold",   32'(dmem.req), 32'd1);
        checkOutput("sh_wdata_hold", dmem.wdata, 32'hABCD_ABCD);
        checkOutput("sh_addr_hold",  dmem.addr, 32'h102);
        setBus(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("sh_done_req",  32'(dmem.req), 32'd0);
        checkOutput("sh_done_busy", 32'(mem_busy_o), 32'd0);
        setBus(1'b0, 1'b0, 32'h0);

        // Misaligned LW 0x101
        applyStimulus(32'h101, 32'h0, T_WS_W, T_RS_MEM, 1'b0, 1'b1, 5'd9);
        @(negedge clk);
        checkOutput("mis_flag",     32'(misaligned_m_o), 32'd1);
        checkOutput("mis_req",      32'(dmem.req), 32'd0);
        checkOutput("mis_regwrite", 32'(reg_write_m_o), 32'd0);
        checkOutput("mis_busy",     32'(mem_busy_o), 32'd0);
        applyBubble();
        @(negedge clk);

        // Forwarding select for the non-memory result sources
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h55, 32'h0, T_WS_W, fwd_rs[i], 1'b0, 1'b1, 5'd3);
            @(negedge clk);
            checkOutput($sformatf("fwd_%0d", i), forward_data_m_o, fwd_exp[i]);
        end

        // Stall holds M, flush overrides stall
        hold = 1'b1;
        applyStimulus(32'h77, 32'h0, T_WS_W, T_RS_ALU, 1'b0, 1'b1, 5'd4);
        @(negedge clk);
        checkOutput("stall_hold", alu_result_m_o, 32'h55);
        applyStimulus(32'h99, 32'h0, T_WS_W, T_RS_ALU, 1'b0, 1'b1, 5'd4);
        flush_m_i = 1'b1;
        @(negedge clk);
        checkOutput("flush_alu", alu_result_m_o, 32'h0);
        checkOutput("flush_rw",  32'(reg_write_m_o), 32'd0);
        flush_m_i = 1'b0;
        hold = 1'b0;

        // Flush in WAIT: the stale response is drained, the next load gets its own data
        applyStimulus(32'h200, 32'h0, T_WS_W, T_RS_MEM, 1'b0, 1'b1, 5'd7);
        @(negedge clk);
        checkOutput("fl_req", 32'(dmem.req), 32'd1);
        setBus(1'b1, 1'b0, 32'h0);
        applyStimulus(32'h300, 32'h0, T_WS_W, T_RS_MEM, 1'b0, 1'b1, 5'd8);
        @(negedge clk);
        setBus(1'b0, 1'b0, 32'h0);
        flush_m_i = 1'b1;
        @(negedge clk);
        flush_m_i = 1'b0;
        checkOutput("drain_busy", 32'(mem_busy_o), 32'd1);
        checkOutput("drain_req",  32'(dmem.req), 32'd0);
        setBus(1'b0, 1'b1, 32'h1111_1111);
        @(negedge clk);
        setBus(1'b0, 1'b0, 32'h0);
        checkOutput("drain_rdata", read_data_m_o, 32'h0);
        checkOutput("drain_idle",  32'(mem_busy_o), 32'd0);
        @(negedge clk);
        checkOutput("lw2_req",  32'(dmem.req), 32'd1);
        checkOutput("lw2_addr", dmem.addr, 32'h300);
        setBus(1'b1, 1'b0, 32'h0);
        applyBubble();
        @(negedge clk);
        setBus(1'b0, 1'b1, 32'h2222_2222);
        @(negedge clk);
        checkOutput("lw2_rdata", read_data_m_o, 32'h2222_2222);
        checkOutput("lw2_rd",    32'(rd_m_o), 32'd8);
        setBus(1'b0, 1'b0, 32'h0);

        // Reset while a load waits for data
        applyStimulus(32'h400, 32'h0, T_WS_W, T_RS_MEM, 1'b0, 1'b1, 5'd10);
        @(negedge clk);
        setBus(1'b1, 1'b0, 32'h0);
        applyBubble();
        @(negedge clk);
        setBus(1'b0, 1'b0, 32'h0);
        checkOutput("wait_busy", 32'(mem_busy_o), 32'd1);
        #2 reset_i = 1'b1;
        #1;
        checkOutput("arst_busy",  32'(mem_busy_o), 32'd0);
        checkOutput("arst_req",   32'(dmem.req), 32'd0);
        checkOutput("arst_rdata", read_data_m_o, 32'd0);
        checkOutput("arst_alu",   alu_result_m_o, 32'd0);
        checkOutput("arst_rd",    32'(rd_m_o), 32'd0);
        checkOutput("arst_rw",    32'(reg_write_m_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_req",  32'(dmem.req), 32'd0);
        checkOutput("post_rst_busy", 32'(mem_busy_o), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
